fold_unpack_three: RTL and testbench
====================================

# fold_unpack_three

Output-side unfolding stage for the 3-folded IIR datapath. The folded datapath delivers one valid 20-bit result per sample period, on a fixed phase of a 3-cycle fold. This block tracks the fold phase from a sample-start strobe and captures the result on the designated phase. It then holds the result as a per-sample output with a one-cycle strobe, and flags phase misalignment.

## Interface
- WIDTH, 20, sample/result width in bits
- FOLD, 3, cycles per sample period (folding factor, ≥2)
- CAPTURE_PHASE, 2, fold phase (0..FOLD-1) on which `in` carries the valid result
- clk  input  1  rising-edge clock, one fold phase per cycle
- rst_n  input  1  reset, asynchronous, active-low; one clock, no other clock domains
- sync  input  1  high for one cycle on phase 0 of a sample period
- in  input  WIDTH  folded datapath result, time-multiplexed
- out  output  WIDTH  unfolded sample, held until next capture
- out_valid  output  1  one-cycle strobe, high in the cycle `out` updates
- phase  output  2  registered current fold phase (0..FOLD-1)
- locked  output  1  high once the first sync has been seen since reset
- sync_err  output  1  one-cycle pulse when a sync arrives off phase 0 while locked
- err_cnt  output  8  saturating count of sync_err events

## Operation
- Phase register `ph` holds the phase for the current cycle. Effective phase `eph` = 0 if sync=1, else `ph`.
- Every cycle: `ph` <= (`eph` == FOLD-1) ? 0 : `eph`+1. Free-running wrap FOLD-1 → 0.
- sync is optional after lock. Without it, the counter free-runs.
- locked: 0 at reset; set in the cycle after the first sync; cleared only by reset.
- Capture: when locked (registered value) is 1 or sync=1, and `eph` == CAPTURE_PHASE, then `out` <= `in` and `out_valid` <= 1. Otherwise `out_valid` <= 0 and `out` holds.
- If CAPTURE_PHASE=0, a sync cycle itself captures.
- Misalignment: sync=1 while locked=1 and `ph` ≠ 0:
  - sync_err <= 1 for one cycle and err_cnt increments, saturating at 255.
  - The phase realigns to 0 in that same cycle, and the capture decision uses the realigned `eph`.
- A sync at `ph`=0 is a no-op realignment, with no error.
- Before lock, `in` is ignored: no captures, and out_valid stays 0.
- Width rule: `in` passes to `out` unmodified. No rounding, truncation or sign handling.

## Timing
- Reset values: out=0, out_valid=0, phase=0, locked=0, sync_err=0, err_cnt=0, and internal `ph`=0.
- Capture latency: `in` sampled at clock edge ending cycle t (`eph`=CAPTURE_PHASE) appears on `out` with out_valid=1 in cycle t+1.
- Steady state: out_valid high exactly 1 of every FOLD cycles. `out` is stable for FOLD cycles between strobes.
- `phase` output equals `ph`; it reflects the registered phase, not `eph`.
- sync_err and the err_cnt update are visible in the cycle after the offending sync.
- Simultaneous sync and capture phase (CAPTURE_PHASE=0): capture occurs; no error if the sync is aligned.
- Simultaneous misaligned sync and err_cnt=255: sync_err pulses, and err_cnt stays 255.
- Reset asserted mid-period: all outputs return to reset values asynchronously. After release, the block requires a new sync before any capture. A result pending at reset is discarded.

## Test plan
- Reset then steady stream (FOLD=3, CAPTURE_PHASE=2): sync at cycle 0, `in`=cycle index → out_valid at cycles 3, 6, 9 with out=2, 5, 8; locked=1 from cycle 1.
- No sync after reset: drive `in` random for 20 cycles → out_valid never high, out=0, locked=0.
- Misaligned sync: lock at cycle 0, extra sync at cycle 4 (ph=1):
  - sync_err pulses at cycle 5 and err_cnt=1.
  - Next capture is the `in` of cycle 6, with out_valid at cycle 7.
- Aligned periodic sync every 3 cycles for 30 cycles → sync_err never high, err_cnt=0, out_valid every 3 cycles.
- Error saturation: 300 misaligned syncs → err_cnt=255 and holds; sync_err still pulses each time.
- Reset mid-operation: assert rst_n low at cycle 7 (after lock), release at 9:
  - All outputs go to 0 immediately.
  - No out_valid until a new sync at cycle 12; first strobe then at cycle 15.

Source files
------------

// File: rtl/fold_unpack_three_if.sv
// Bus between the 3-folded IIR datapath output and the unfolding stage.
// master: drives sync strobe and folded result, observes unfolded outputs.
// slave : the unfolding stage itself.
interface fold_unpack_three_if #(
    parameter int unsigned WIDTH = 20
);
    logic              sync;       // phase-0 strobe of a sample period
    logic [WIDTH-1:0]  in;         // time-multiplexed folded result
    logic [WIDTH-1:0]  out;        // unfolded sample, held between captures
    logic              out_valid;  // one-cycle strobe when out updates
    logic [1:0]        phase;      // registered fold phase
    logic              locked;     // first sync seen since reset
    logic              sync_err;   // pulse on misaligned sync while locked
    logic [7:0]        err_cnt;    // saturating misalignment count

    modport master (
        output sync, in,
        input  out, out_valid, phase, locked, sync_err, err_cnt
    );

    modport slave (
        input  sync, in,
        output out, out_valid, phase, locked, sync_err, err_cnt
    );
endinterface

// File: rtl/fold_unpack_three.sv
// Output-side unfolding stage for the folded IIR datapath.
// Tracks the fold phase from the sync strobe, captures the folded result on
// CAPTURE_PHASE and presents it as a held sample with a one-cycle strobe.
// Ports:
//   clk   - rising-edge clock, one fold phase per cycle
//   rst_n - asynchronous active-low reset
//   bus   - slave side: sync/in in; out/out_valid/phase/locked/sync_err/err_cnt out
module fold_unpack_three #(
    parameter int unsigned WIDTH         = 20,
    parameter int unsigned FOLD          = 3,
    parameter int unsigned CAPTURE_PHASE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    fold_unpack_three_if.slave bus
);
    localparam int unsigned PH_W  = 2;
    localparam int unsigned CNT_W = 8;

    logic [PH_W-1:0]  r_ph;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic             r_locked;
    logic             r_sync_err;
    logic [CNT_W-1:0] r_err_cnt;

    logic [PH_W-1:0]  w_eph;
    logic [PH_W-1:0]  w_ph_nxt;
    logic             w_cap;
    logic             w_err;

    // Effective phase: a sync forces phase 0 in the same cycle it arrives.
    always_comb begin
        w_eph    = r_ph;
        w_ph_nxt = '0;
        w_cap    = 1'b0;
        w_err    = 1'b0;
        if (bus.sync) begin
            w_eph = '0;
        end
        if (w_eph != PH_W'(FOLD - 1)) begin
            w_ph_nxt = w_eph + PH_W'(1);
        end
        // The sync cycle itself may capture, before locked has registered.
        w_cap = (r_locked | bus.sync) & (w_eph == PH_W'(CAPTURE_PHASE));
        w_err = bus.sync & r_locked & (r_ph != '0);
    end

    // Phase, capture and error-tracking state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_sync_err  <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_ph        <= w_ph_nxt;
            r_out_valid <= w_cap;
            r_sync_err  <= w_err;
            if (w_cap) begin
                r_out <= bus.in;
            end
            if (w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (bus.sync) begin
                r_locked <= 1'b1;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.phase     = r_ph;
    assign bus.locked    = r_locked;
    assign bus.sync_err  = r_sync_err;
    assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_fold_unpack_three.sv
module tb_fold_unpack_three;
    localparam int W  = 20;
    localparam int F  = 3;
    localparam int CP = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fold_unpack_three_if #(.WIDTH(W)) bus ();

    fold_unpack_three #(.WIDTH(W), .FOLD(F), .CAPTURE_PHASE(CP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer phase counter modulo FOLD plus output state.
    int          m_ph;
    bit          m_locked;
    logic [W-1:0] m_out;
    bit          m_valid;
    bit          m_err;
    int          m_cnt;

    function automatic logic [W+13:0] model_vec();
        return {m_out, m_valid, 2'(m_ph), m_locked, m_err, 8'(m_cnt)};
    endfunction

    function automatic logic [W+13:0] dut_vec();
        return {bus.out, bus.out_valid, bus.phase, bus.locked, bus.sync_err, bus.err_cnt};
    endfunction

    task automatic model_reset();
        m_ph = 0; m_locked = 0; m_out = '0; m_valid = 0; m_err = 0; m_cnt = 0;
    endtask

    // One sample-period cycle: apply inputs, advance model, clock, settle.
    task automatic tick(input logic s, input logic [W-1:0] d);
        int eph;
        bus.sync = s;
        bus.in   = d;
        if (rst_n) begin
            eph     = s ? 0 : m_ph;
            m_valid = (m_locked || s) && (eph == CP);
            if (m_valid) m_out = d;
            m_err   = s && m_locked && (m_ph != 0);
            if (m_err && m_cnt < 255) m_cnt = m_cnt + 1;
            if (s) m_locked = 1;
            m_ph    = (eph + 1) % F;
        end else begin
            model_reset();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.sync = 1'b0;
        bus.in   = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== {(W+14){1'b0}}) begin
            n_errors++;
            $display("FAIL reset_state got=%h want=0", dut_vec());
        end
        do_reset();
        n_checks++;
        if (dut_vec() !== model_vec()) begin
            n_errors++;
            $display("FAIL reset_release got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_no_sync();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, W'($urandom));
            n_checks++;
            if ({bus.out_valid, bus.out, bus.locked} !== {1'b0, {W{1'b0}}, 1'b0}) begin
                n_errors++;
                $display("FAIL no_sync cyc=%0d got v=%b out=%h lk=%b want 0/0/0",
                         i, bus.out_valid, bus.out, bus.locked);
            end
        end
    endtask

    task automatic test_steady();
        logic exp_v;
        do_reset();
        for (int t = 0; t < 12; t++) begin
            tick(t == 0, W'(t));
            // observing cycle t+1
            exp_v = ((t + 1) % 3 == 0);
            n_checks++;
            if (bus.out_valid !== exp_v || (exp_v && bus.out !== W'(t)) || bus.locked !== 1'b1) begin
                n_errors++;
                $display("FAIL steady cyc=%0d got v=%b out=%0d lk=%b want v=%b out=%0d lk=1",
                         t + 1, bus.out_valid, bus.out, bus.locked, exp_v, t);
            end
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL steady_model cyc=%0d got=%h want=%h", t + 1, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_misaligned();
        logic [W-1:0] d6;
        do_reset();
        d6 = '0;
        for (int t = 0; t < 9; t++) begin
            logic [W-1:0] d;
            d = W'($urandom);
            if (t == 6) d6 = d;
            tick(t == 0 || t == 4, d);
            if (t == 4) begin
                n_checks++;
                if (bus.sync_err !== 1'b1 || bus.err_cnt !== 8'd1) begin
                    n_errors++;
                    $display("FAIL misalign_err got err=%b cnt=%0d want 1/1", bus.sync_err, bus.err_cnt);
                end
            end
            if (t == 5) begin
                n_checks++;
                if (bus.out_valid !== 1'b0 || bus.sync_err !== 1'b0) begin
                    n_errors++;
                    $display("FAIL misalign_gap got v=%b err=%b want 0/0", bus.out_valid, bus.sync_err);
                end
            end
            if (t == 6) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out !== d6) begin
                    n_errors++;
                    $display("FAIL misalign_cap got v=%b out=%h want 1/%h", bus.out_valid, bus.out, d6);
                end
            end
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL misalign_model cyc=%0d got=%h want=%h", t + 1, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_aligned_periodic();
        do_reset();
        for (int t = 0; t < 30; t++) begin
            tick(t % 3 == 0, W'($urandom));
            n_checks++;
            if (bus.sync_err !== 1'b0 || bus.err_cnt !== 8'd0 ||
                bus.out_valid !== ((t + 1) % 3 == 0)) begin
                n_errors++;
                $display("FAIL aligned cyc=%0d got err=%b cnt=%0d v=%b", t + 1,
                         bus.sync_err, bus.err_cnt, bus.out_valid);
            end
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL aligned_model cyc=%0d got=%h want=%h", t + 1, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        do_reset();
        tick(1'b1, W'($urandom));
        // continuous sync: every later sync lands on phase 1
        for (int i = 1; i <= 300; i++) begin
            tick(1'b1, W'($urandom));
            exp_cnt = (i > 255) ? 255 : i;
            n_checks++;
            if (bus.sync_err !== 1'b1 || bus.err_cnt !== 8'(exp_cnt)) begin
                n_errors++;
                $display("FAIL saturate n=%0d got err=%b cnt=%0d want 1/%0d",
                         i, bus.sync_err, bus.err_cnt, exp_cnt);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, W'($urandom));
            n_checks++;
            if (bus.sync_err !== 1'b0 || bus.err_cnt !== 8'd255) begin
                n_errors++;
                $display("FAIL saturate_hold got err=%b cnt=%0d want 0/255", bus.sync_err, bus.err_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d14;
        do_reset();
        d14 = '0;
        for (int t = 0; t < 7; t++) tick(t == 0, W'(t + 100));
        // now in cycle 7: asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== {(W+14){1'b0}}) begin
            n_errors++;
            $display("FAIL reset_mid_async got=%h want=0", dut_vec());
        end
        tick(1'b0, W'($urandom));   // cycle 7
        tick(1'b0, W'($urandom));   // cycle 8
        rst_n = 1'b1;
        for (int t = 9; t < 15; t++) begin
            logic [W-1:0] d;
            d = W'($urandom);
            if (t == 14) d14 = d;
            tick(t == 12, d);
            n_checks++;
            if (bus.out_valid !== (t == 14) || (t == 14 && bus.out !== d14)) begin
                n_errors++;
                $display("FAIL reset_mid cyc=%0d got v=%b out=%h want v=%b out=%h",
                         t + 1, bus.out_valid, bus.out, (t == 14), d14);
            end
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL reset_mid_model cyc=%0d got=%h want=%h", t + 1, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 300; t++) begin
            tick($urandom_range(0, 6) == 0, W'($urandom));
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL random cyc=%0d got=%h want=%h", t + 1, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.sync = 1'b0;
        bus.in   = '0;
        model_reset();
        test_reset();
        test_no_sync();
        test_steady();
        test_misaligned();
        test_aligned_periodic();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
